// File: rtl/zigzag_pp_buf_pkg.sv
// Shared definitions for the 8x8 coefficient reorder path: block geometry
// and the zigzag-to-raster address map used by encoder and decoder models.
package jpeg_zz_pkg;

    localparam int BLK_SIZE = 64;
    localparam int IDX_W    = 6;

    typedef logic [IDX_W-1:0] blk_idx_t;

    // Entry n is the raster (row-major) position of the n-th zigzag coefficient.
    localparam blk_idx_t ZZ_ROM [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic blk_idx_t zz_addr(input blk_idx_t idx);
        return ZZ_ROM[idx];
    endfunction

endpackage

// File: rtl/zigzag_pp_buf_if.sv
// Coefficient stream bundle: raster-order input side with zigzag select,
// reordered output side carrying scan index and end-of-block marker.
interface zigzag_pp_buf_if import jpeg_zz_pkg::*; #(parameter int DW = 42);

    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           zz_en;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    blk_idx_t       out_idx;
    logic           out_last;

    // The reorder buffer itself.
    modport slave (
        input  in_valid, in_data, zz_en, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    // Quantiser-side producer and entropy-coder-side consumer.
    modport master (
        output in_valid, in_data, zz_en, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/zigzag_pp_buf_bank_ram.sv
// Banked coefficient store: one write port, one read port with a registered
// output that holds between reads. Swap this module for a block-RAM macro.
module zigzag_bank_ram import jpeg_zz_pkg::*; #(
    parameter int DW   = 42,
    parameter int NBUF = 2,
    parameter int AW   = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DW-1:0]  din,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [DW-1:0]  dout
);

    logic [DW-1:0] mem [NBUF*BLK_SIZE];

    // Array contents are deliberately left unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    // Read register: only the output flop is cleared, it otherwise holds on idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/zigzag_pp_buf.sv
// Multi-bank 8x8 coefficient reorder buffer. Blocks arrive in raster order,
// one bank fills while an older one drains in zigzag or raster order. The
// per-bank full flag is the only arbiter between the two sides.
module zigzag_pp_buf import jpeg_zz_pkg::*; #(
    parameter int DW   = 42,
    parameter int NBUF = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    zigzag_pp_buf_if.slave        bus
);

    localparam int BW = $clog2(NBUF);
    localparam int AW = BW + IDX_W;

    logic [BW-1:0]   wr_bank;
    blk_idx_t        wr_cnt;
    logic [BW-1:0]   rd_bank;
    blk_idx_t        rd_cnt;
    logic [NBUF-1:0] full;
    logic            zz_sel;

    logic            out_valid_q;
    blk_idx_t        out_idx_q;
    logic            out_last_q;

    logic            wr_fire;
    logic            wr_blk_end;
    logic            rd_issue;
    logic            rd_blk_end;
    logic            blk_zz;
    blk_idx_t        rd_off;

    // Write side is gated only by the target bank still waiting to drain.
    assign bus.in_ready = !rst && !full[wr_bank];
    assign wr_fire      = bus.in_valid && bus.in_ready;
    assign wr_blk_end   = wr_fire && (wr_cnt == 6'd63);

    // A read refills the output register whenever it is empty or being consumed.
    assign rd_issue   = full[rd_bank] && (!out_valid_q || bus.out_ready);
    assign rd_blk_end = rd_issue && (rd_cnt == 6'd63);

    // The first read of a block takes zz_en live; the rest use the latched copy.
    assign blk_zz = (rd_cnt == 6'd0) ? bus.zz_en : zz_sel;
    assign rd_off = blk_zz ? zz_addr(rd_cnt) : rd_cnt;

    // Write pointer: offset within the block and the bank being filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= '0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) begin
                wr_bank <= wr_bank + BW'(1);
            end
        end
    end

    // Read pointer: scan index within the block and the bank being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= '0;
        end else if (rd_issue) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd63) begin
                rd_bank <= rd_bank + BW'(1);
            end
        end
    end

    // Bank ownership: set on the last write, cleared on the last read issue.
    // The two sides always target different banks, so both may fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wr_blk_end) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_blk_end) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Scan mode is frozen per block so mid-block zz_en changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            zz_sel <= 1'b0;
        end else if (rd_issue && (rd_cnt == 6'd0)) begin
            zz_sel <= bus.zz_en;
        end
    end

    // Output qualifiers track the RAM read register one cycle behind the issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (rd_issue) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= rd_cnt;
            out_last_q  <= (rd_cnt == 6'd63);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

    zigzag_bank_ram #(
        .DW   (DW),
        .NBUF (NBUF),
        .AW   (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr ({wr_bank, wr_cnt}),
        .din   (bus.in_data),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_off}),
        .dout  (bus.out_data)
    );

endmodule

// File: tb/tb_zigzag_pp_buf.sv
// Bench for the coefficient reorder buffer: one NBUF=2 and one NBUF=4
// instance, a block-level scoreboard and directed plus random scenarios.
module tb_zigzag_pp_buf;

    localparam int DW = 42;
    localparam int EW = DW + 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           vld   [2];
    logic [DW-1:0]  din   [2];
    logic           zz    [2];
    logic           ordy  [2];
    logic           irdy  [2];
    logic           ovld  [2];
    logic [DW-1:0]  odata [2];
    logic [5:0]     oidx  [2];
    logic           olast [2];

    zigzag_pp_buf_if #(.DW(DW)) if2 ();
    zigzag_pp_buf_if #(.DW(DW)) if4 ();

    assign if2.in_valid  = vld[0];
    assign if2.in_data   = din[0];
    assign if2.zz_en     = zz[0];
    assign if2.out_ready = ordy[0];
    assign irdy[0]  = if2.in_ready;
    assign ovld[0]  = if2.out_valid;
    assign odata[0] = if2.out_data;
    assign oidx[0]  = if2.out_idx;
    assign olast[0] = if2.out_last;

    assign if4.in_valid  = vld[1];
    assign if4.in_data   = din[1];
    assign if4.zz_en     = zz[1];
    assign if4.out_ready = ordy[1];
    assign irdy[1]  = if4.in_ready;
    assign ovld[1]  = if4.out_valid;
    assign odata[1] = if4.out_data;
    assign oidx[1]  = if4.out_idx;
    assign olast[1] = if4.out_last;

    zigzag_pp_buf #(.DW(DW), .NBUF(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    zigzag_pp_buf #(.DW(DW), .NBUF(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    int checks;
    int passed;
    int cyc;

    // reference model state
    int             zzmap     [64];
    logic [EW-1:0]  exp_mem   [2][1024];
    int             wp        [2];
    int             rp        [2];
    logic [DW-1:0]  part      [2][64];
    int             pcnt      [2];
    int             blk_cnt   [2];
    int             out_cnt   [2];
    logic           mode_tab  [2][32];
    logic           stall_prev[2];
    logic [EW-1:0]  held      [2];
    int             last_hs_cyc[2];
    logic [DW-1:0]  pin_obs   [8];

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // scoreboard: builds expected output per completed input block and
    // checks every consumed word and every stalled cycle
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        int src;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    wp[k] = 0; rp[k] = 0; pcnt[k] = 0; blk_cnt[k] = 0;
                    out_cnt[k] = 0; stall_prev[k] = 1'b0;
                end else begin
                    if (vld[k] && irdy[k]) begin
                        part[k][pcnt[k]] = din[k];
                        pcnt[k]++;
                        last_hs_cyc[k] = cyc;
                        if (pcnt[k] == 64) begin
                            for (int n = 0; n < 64; n++) begin
                                src = mode_tab[k][blk_cnt[k] % 32] ? zzmap[n] : n;
                                exp_mem[k][wp[k] % 1024] = {(n == 63), 6'(n), part[k][src]};
                                wp[k]++;
                            end
                            pcnt[k] = 0;
                            blk_cnt[k]++;
                        end
                    end
                    got = {olast[k], oidx[k], odata[k]};
                    if (stall_prev[k])
                        check(k == 0 ? "hold_n2" : "hold_n4",
                              ovld[k] && (got == held[k]), {ovld[k], got}, {1'b1, held[k]});
                    if (ovld[k] && ordy[k]) begin
                        if (rp[k] == wp[k]) begin
                            check(k == 0 ? "spurious_n2" : "spurious_n4", 1'b0, got, 0);
                        end else begin
                            e = exp_mem[k][rp[k] % 1024];
                            rp[k]++;
                            check(k == 0 ? "word_n2" : "word_n4", got == e, got, e);
                        end
                        if (k == 0 && out_cnt[0] < 8) pin_obs[out_cnt[0]] = odata[0];
                        out_cnt[k]++;
                    end
                    stall_prev[k] = ovld[k] && !ordy[k];
                    held[k] = got;
                end
            end
        end
    end

    task automatic send(input int k, input logic [DW-1:0] d);
        logic ok;
        ok = 1'b0;
        vld[k] = 1'b1;
        din[k] = d;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (irdy[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 1'b0, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rdy_in_rst", !irdy[0] && !irdy[1], {irdy[0], irdy[1]}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0;
        @(negedge clk);
        check("valid_after_rst", !ovld[0] && !ovld[1], {ovld[0], ovld[1]}, 0);
        check("rdy_after_rst", irdy[0] && irdy[1], {irdy[0], irdy[1]}, 2'b11);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int k);
        for (int t = 0; t < 5000; t++) begin
            if (rp[k] == wp[k] && !ovld[k]) break;
            @(negedge clk);
        end
        check("drain", rp[k] == wp[k], rp[k], wp[k]);
    endtask

    task automatic rand_run(input int k);
        fork
            begin
                int sent;
                logic hs;
                sent = 0;
                din[k] = DW'({$urandom, $urandom});
                vld[k] = 1'($urandom % 2);
                for (int t = 0; t < 20000; t++) begin
                    @(negedge clk);
                    hs = vld[k] && irdy[k];
                    if (hs) sent++;
                    @(posedge clk); #1;
                    if (sent == 1024) break;
                    if (hs) din[k] = DW'({$urandom, $urandom});
                    vld[k] = 1'($urandom % 2);
                end
                vld[k] = 1'b0;
                check("rand_sent", sent == 1024, sent, 1024);
            end
            begin
                for (int t = 0; t < 20000 && out_cnt[k] < 1024; t++) begin
                    @(posedge clk); #1;
                    ordy[k] = 1'($urandom % 2);
                end
                ordy[k] = 1'b1;
            end
        join
    endtask

    initial begin
        int n, hs, fv, acc, r0, rise, lastc;
        logic [DW-1:0] pin_exp [8];
        checks = 0; passed = 0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; din[k] = '0; zz[k] = 1'b1; ordy[k] = 1'b1;
            for (int b = 0; b < 32; b++) mode_tab[k][b] = 1'b1;
        end

        // zigzag map by walking anti-diagonals, alternating direction
        n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zzmap[n] = r * 8 + (s - r); n++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zzmap[n] = r * 8 + (s - r); n++;
                end
            end
        end
        check("map_2",  zzmap[2]  == 8,  zzmap[2],  8);
        check("map_6",  zzmap[6]  == 3,  zzmap[6],  3);
        check("map_10", zzmap[10] == 32, zzmap[10], 32);
        check("map_20", zzmap[20] == 40, zzmap[20], 40);
        check("map_62", zzmap[62] == 62, zzmap[62], 62);
        check("map_63", zzmap[63] == 63, zzmap[63], 63);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs",
              !ovld[0] && !irdy[0] && odata[0] == '0 && oidx[0] == 6'd0 && !olast[0],
              {ovld[0], irdy[0], olast[0], oidx[0], odata[0]}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rdy_first", irdy[0], irdy[0], 1);
        @(posedge clk); #1;

        // single block, zigzag readout, latency and literal order
        for (int i = 0; i < 64; i++) send(0, DW'(i));
        vld[0] = 1'b0;
        hs = last_hs_cyc[0];
        fv = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ovld[0]) begin fv = cyc; break; end
        end
        check("latency", fv - hs == 2, fv - hs, 2);
        wait_drain(0);
        pin_exp = '{0, 1, 8, 16, 9, 2, 3, 10};
        for (int i = 0; i < 8; i++) check("pin_order", pin_obs[i] == pin_exp[i], pin_obs[i], pin_exp[i]);
        check("single_count", out_cnt[0] == 64, out_cnt[0], 64);

        // raster block, zz_en flipped at output word 20, next block zigzag
        do_reset();
        mode_tab[0][0] = 1'b0;
        mode_tab[0][1] = 1'b1;
        zz[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 128; i++) send(0, DW'(i));
                vld[0] = 1'b0;
            end
            begin
                for (int t = 0; t < 1000; t++) begin
                    @(negedge clk);
                    if (out_cnt[0] >= 20) break;
                end
                @(posedge clk); #1;
                zz[0] = 1'b1;
            end
        join
        wait_drain(0);
        check("toggle_count", out_cnt[0] == 128, out_cnt[0], 128);
        mode_tab[0][0] = 1'b1;

        // full/backpressure on NBUF=2
        do_reset();
        ordy[0] = 1'b0;
        acc = 0;
        vld[0] = 1'b1;
        din[0] = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (vld[0] && irdy[0]) acc++;
            @(posedge clk); #1;
            din[0] = DW'(acc);
        end
        check("accept_before_full", acc == 128, acc, 128);
        check("rdy_low_full", !irdy[0], irdy[0], 0);
        ordy[0] = 1'b1;
        r0 = cyc;
        rise = -1; lastc = -1;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (vld[0] && irdy[0]) acc++;
            if (rise < 0 && irdy[0]) rise = cyc;
            if (lastc < 0 && ovld[0] && olast[0]) lastc = cyc;
            @(posedge clk); #1;
            if (acc >= 200) vld[0] = 1'b0;
            else din[0] = DW'(acc);
            if (acc >= 200 && rise >= 0 && lastc >= 0) break;
        end
        check("rdy_return_delay", rise - r0 == 63, rise - r0, 63);
        check("rdy_vs_last", rise == lastc, rise, lastc);
        wait_drain(0);
        check("bp_count", out_cnt[0] == 192, out_cnt[0], 192);

        // reset during block 1 while block 0 drains
        do_reset();
        for (int i = 0; i < 104; i++) send(0, DW'(1000 + i));
        do_reset();
        for (int i = 0; i < 64; i++) send(0, DW'(2000 + i));
        vld[0] = 1'b0;
        fv = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ovld[0]) begin fv = oidx[0]; break; end
        end
        check("post_rst_idx0", fv == 0, fv, 0);
        wait_drain(0);
        check("post_rst_count", out_cnt[0] == 64, out_cnt[0], 64);

        // random stalls on both bank counts
        do_reset();
        zz[0] = 1'b1; zz[1] = 1'b1;
        fork
            rand_run(0);
            rand_run(1);
        join
        wait_drain(0);
        wait_drain(1);
        check("rand_count_n2", out_cnt[0] == 1024, out_cnt[0], 1024);
        check("rand_count_n4", out_cnt[1] == 1024, out_cnt[1], 1024);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
